// File: rtl/ranging_scheduler.sv
// ranging_scheduler: periodic ultrasonic range sequencer.
// Fires a start pulse once per period, waits for the sensor result or a
// timeout, median-filters the last three valid distances and pushes the
// result to the display driver over req/ack. A write happens only when
// the filtered value or the error flag changes.
module ranging_scheduler #(
  parameter int PERIOD_CYC  = 3000000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int DIST_W      = 12,
  parameter int MAX_DIST    = 400,
  parameter int ERR_LIMIT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              meas_start,
  input  logic              meas_done,
  input  logic [DIST_W-1:0] meas_dist,
  output logic              disp_req,
  input  logic              disp_ack,
  output logic [DIST_W-1:0] disp_dist,
  output logic              disp_err,
  output logic              overrun
);

  localparam int PER_W = $clog2(PERIOD_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, EVAL, SEND} state_t;

  state_t            state;
  logic [PER_W-1:0]  per_cnt;
  logic              tick;
  logic [TO_W-1:0]   to_cnt;

  // Latched outcome of the WAIT phase, consumed in EVAL.
  logic              sample_ok;
  logic [DIST_W-1:0] sample;

  // Three-entry history, s0 is the newest sample.
  logic [DIST_W-1:0] s0, s1, s2;
  logic [1:0]        cnt;
  logic [ERR_W-1:0]  err_cnt;

  // Last values acknowledged by the display driver.
  logic [DIST_W-1:0] last_dist;
  logic              last_err;

  // Next-state values computed for EVAL.
  logic [DIST_W-1:0] s0_n, s1_n, s2_n;
  logic [1:0]        cnt_n;
  logic [ERR_W-1:0]  err_n;
  logic [DIST_W-1:0] lo, hi, mid, med;
  logic [DIST_W-1:0] new_dist;
  logic              new_err;
  logic              changed;

  assign tick = enable && (per_cnt == PER_W'(PERIOD_CYC - 1));

  // Period counter: free-runs while enabled, wraps on tick, clears when disabled.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples the pre-edge values of its inputs regardless of block ordering.
    if (!rst) begin
      per_cnt <= '0;
    end else if (!enable || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  // EVAL datapath: buffer/error update, median and change detection.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    s0_n  = s0;
    s1_n  = s1;
    s2_n  = s2;
    cnt_n = cnt;
    err_n = err_cnt;
    if (sample_ok) begin
      s0_n  = sample;
      s1_n  = s0;
      s2_n  = s1;
      err_n = '0;
      if (cnt != 2'd3) cnt_n = cnt + 2'd1;
    end else if (err_cnt != ERR_W'(ERR_LIMIT)) begin
      err_n = err_cnt + ERR_W'(1);
    end

    // median(a,b,c) = max(min(a,b), min(max(a,b),c)), unsigned compares only
    lo  = (s0_n < s1_n) ? s0_n : s1_n;
    hi  = (s0_n < s1_n) ? s1_n : s0_n;
    mid = (hi < s2_n) ? hi : s2_n;
    med = (lo > mid) ? lo : mid;

    case (cnt_n)
      2'd3:    new_dist = med;
      2'd0:    new_dist = '0;
      default: new_dist = s0_n;
    endcase

    new_err = (err_n == ERR_W'(ERR_LIMIT));
    changed = (new_dist != last_dist) || (new_err != last_err);
  end

  // Measurement sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      meas_start <= 1'b0;
      to_cnt     <= '0;
      sample_ok  <= 1'b0;
      sample     <= '0;
      s0         <= '0;
      s1         <= '0;
      s2         <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      last_dist  <= '0;
      last_err   <= 1'b0;
      disp_req   <= 1'b0;
      disp_dist  <= '0;
      disp_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A tick outside IDLE means the previous sequence ran over its period.
      if (tick && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            state      <= TRIG;
            meas_start <= 1'b1;
          end
        end

        TRIG: begin
          meas_start <= 1'b0;
          to_cnt     <= '0;
          state      <= WAIT;
        end

        WAIT: begin
          // meas_done is checked first so it wins over a same-cycle timeout.
          if (meas_done) begin
            sample_ok <= (meas_dist <= DIST_W'(MAX_DIST));
            sample    <= meas_dist;
            state     <= EVAL;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            sample_ok <= 1'b0;
            state     <= EVAL;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        EVAL: begin
          s0      <= s0_n;
          s1      <= s1_n;
          s2      <= s2_n;
          cnt     <= cnt_n;
          err_cnt <= err_n;
          if (changed) begin
            disp_dist <= new_dist;
            disp_err  <= new_err;
            disp_req  <= 1'b1;
            state     <= SEND;
          end else begin
            state <= IDLE;
          end
        end

        SEND: begin
          // Hold data until acknowledged; no ack timeout.
          if (disp_ack) begin
            disp_req  <= 1'b0;
            last_dist <= disp_dist;
            last_err  <= disp_err;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ranging_scheduler.sv
// Directed testbench for ranging_scheduler with short period/timeout values.
module tb_ranging_scheduler;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          meas_start;
  logic          meas_done = 1'b0;
  logic [DW-1:0] meas_dist = '0;
  logic          disp_req;
  logic          disp_ack = 1'b0;
  logic [DW-1:0] disp_dist;
  logic          disp_err;
  logic          overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Display-side model: counts request rises, captures data, acks 3 cycles in.
  int            req_rises = 0;
  logic [DW-1:0] req_dist  = '0;
  logic          req_err   = 1'b0;
  logic          req_q     = 1'b0;
  int            req_age   = 0;
  bit            ack_hold  = 1'b0;

  ranging_scheduler #(
    .PERIOD_CYC (100),
    .TIMEOUT_CYC(40),
    .DIST_W     (DW),
    .MAX_DIST   (400),
    .ERR_LIMIT  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .meas_start(meas_start),
    .meas_done (meas_done),
    .meas_dist (meas_dist),
    .disp_req  (disp_req),
    .disp_ack  (disp_ack),
    .disp_dist (disp_dist),
    .disp_err  (disp_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Display driver model, evaluated on the falling edge.
  always @(negedge clk) begin
    if (disp_req && !req_q) begin
      req_rises = req_rises + 1;
      req_dist  = disp_dist;
      req_err   = disp_err;
    end
    req_q   = disp_req;
    req_age = disp_req ? req_age + 1 : 0;
    disp_ack = disp_req && !ack_hold && (req_age >= 3);
  end

  task automatic do_reset();
    rst    = 1'b0;
    enable = 1'b1;
    meas_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Waits (bounded) for meas_start; returns the number of rising edges taken.
  task automatic wait_start(output int cyc);
    bit found;
    found = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= 150 && !found; i++) begin
      @(posedge clk);
      #1;
      if (meas_start) begin
        found = 1'b1;
        cyc   = i;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL meas_start_wait: no meas_start within 150 cycles");
    end
  endtask

  // One measurement period: optional response k cycles into WAIT, with
  // latency check of disp_req (low in EVAL, exp_req in the following cycle).
  task automatic run_meas(input bit give_done, input int k, input logic [DW-1:0] d,
                          input bit exp_req, input string name);
    int cyc;
    wait_start(cyc);
    if (give_done) begin
      repeat (k) @(posedge clk);
      #1 meas_done = 1'b1;
      meas_dist = d;
      @(posedge clk);
      #1 meas_done = 1'b0;
      n_checks++;
      if (disp_req !== 1'b0) $display("FAIL %s_eval_req: got %b want 0", name, disp_req);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (disp_req !== exp_req) $display("FAIL %s_req_latency: got %b want %b", name, disp_req, exp_req);
      else n_pass++;
      repeat (50) @(posedge clk);
    end else begin
      repeat (55) @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    int cyc, r0;
    rst = 1'b0;
    enable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({meas_start, disp_req, disp_err, overrun} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {meas_start, disp_req, disp_err, overrun});
    else n_pass++;
    n_checks++;
    if (disp_dist !== '0) $display("FAIL reset_dist: got %0d want 0", disp_dist);
    else n_pass++;
    r0 = req_rises;
    rst = 1'b1;
    wait_start(cyc);
    n_checks++;
    if (cyc !== 100) $display("FAIL first_start: got %0d cycles want 100", cyc);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (meas_start !== 1'b0) $display("FAIL start_width: got %b want 0", meas_start);
    else n_pass++;
    wait_start(cyc);
    n_checks++;
    if (cyc + 1 !== 100) $display("FAIL start_interval: got %0d want 100", cyc + 1);
    else n_pass++;
    // The two unanswered periods are silent timeouts, below the error limit.
    n_checks++;
    if (req_rises - r0 !== 0) $display("FAIL reset_no_req: got %0d want 0", req_rises - r0);
    else n_pass++;
  endtask

  task automatic test_filtering();
    int r0;
    do_reset();
    r0 = req_rises;
    run_meas(1, 5, 50, 1, "filt50");
    n_checks++;
    if (req_dist !== 50) $display("FAIL filt50_dist: got %0d want 50", req_dist);
    else n_pass++;
    run_meas(1, 5, 52, 1, "filt52");
    n_checks++;
    if (req_dist !== 52) $display("FAIL filt52_dist: got %0d want 52", req_dist);
    else n_pass++;
    run_meas(1, 5, 200, 0, "filt200");
    n_checks++;
    if (disp_dist !== 52) $display("FAIL filt_median: got %0d want 52", disp_dist);
    else n_pass++;
    n_checks++;
    if (req_rises - r0 !== 2) $display("FAIL filt_req_count: got %0d want 2", req_rises - r0);
    else n_pass++;
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL filt_overrun: got %b want 0", overrun);
    else n_pass++;
  endtask

  task automatic test_duplicate();
    int r0;
    do_reset();
    r0 = req_rises;
    run_meas(1, 10, 60, 1, "dup1");
    n_checks++;
    if (req_dist !== 60) $display("FAIL dup_first_dist: got %0d want 60", req_dist);
    else n_pass++;
    run_meas(1, 10, 60, 0, "dup2");
    run_meas(1, 10, 60, 0, "dup3");
    run_meas(1, 10, 60, 0, "dup4");
    n_checks++;
    if (req_rises - r0 !== 1) $display("FAIL dup_req_count: got %0d want 1", req_rises - r0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int r0;
    do_reset();
    r0 = req_rises;
    run_meas(0, 0, 0, 0, "to1");
    run_meas(0, 0, 0, 0, "to2");
    n_checks++;
    if (req_rises - r0 !== 0) $display("FAIL to_early_req: got %0d want 0", req_rises - r0);
    else n_pass++;
    run_meas(0, 0, 0, 0, "to3");
    n_checks++;
    if (req_rises - r0 !== 1) $display("FAIL to_err_req: got %0d want 1", req_rises - r0);
    else n_pass++;
    n_checks++;
    if ({req_err, req_dist} !== {1'b1, 12'd0}) $display("FAIL to_err_data: got err=%b dist=%0d want err=1 dist=0", req_err, req_dist);
    else n_pass++;
    run_meas(1, 3, 75, 1, "to_recover");
    n_checks++;
    if ({req_err, req_dist} !== {1'b0, 12'd75}) $display("FAIL to_recover_data: got err=%b dist=%0d want err=0 dist=75", req_err, req_dist);
    else n_pass++;
  endtask

  task automatic test_range_collision();
    int r0;
    do_reset();
    r0 = req_rises;
    run_meas(1, 4, 401, 0, "range401");
    n_checks++;
    if (req_rises - r0 !== 0) $display("FAIL range401_req: got %0d want 0", req_rises - r0);
    else n_pass++;
    // Response lands on the last WAIT cycle, where the timeout would fire.
    run_meas(1, 40, 100, 1, "collide");
    n_checks++;
    if (req_dist !== 100) $display("FAIL collide_dist: got %0d want 100", req_dist);
    else n_pass++;
    // Stray meas_done while idle must be ignored.
    r0 = req_rises;
    meas_done = 1'b1;
    meas_dist = 300;
    @(posedge clk);
    #1 meas_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (req_rises - r0 !== 0 || meas_start !== 1'b0) $display("FAIL idle_done_ignored: got reqs=%0d start=%b want 0 0", req_rises - r0, meas_start);
    else n_pass++;
    n_checks++;
    if (disp_dist !== 100) $display("FAIL idle_done_dist: got %0d want 100", disp_dist);
    else n_pass++;
    run_meas(1, 4, 400, 1, "range400");
    n_checks++;
    if (req_dist !== 400) $display("FAIL range400_dist: got %0d want 400", req_dist);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    ack_hold = 1'b1;
    run_meas(1, 5, 80, 1, "ovr");
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL ovr_before: got %b want 0", overrun);
    else n_pass++;
    repeat (150) @(posedge clk);
    #1;
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun);
    else n_pass++;
    n_checks++;
    if ({disp_req, disp_err, disp_dist} !== {1'b1, 1'b0, 12'd80}) $display("FAIL ovr_hold: got req=%b err=%b dist=%0d want 1 0 80", disp_req, disp_err, disp_dist);
    else n_pass++;
    // Asynchronous reset in the middle of a clock phase.
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({disp_req, overrun, meas_start, disp_err} !== 4'b0 || disp_dist !== '0) $display("FAIL async_reset: got req=%b ovr=%b start=%b err=%b dist=%0d want all 0", disp_req, overrun, meas_start, disp_err, disp_dist);
    else n_pass++;
    ack_hold = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_filtering();
    test_duplicate();
    test_timeout();
    test_range_collision();
    test_overrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
